// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: ALU_control op codes
// (as produced by the ALU decoder) and the execution FSM state encoding.
package alu_pkg;

   // ALU_control op codes; the decoder emits these same values
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SLL = 3'b001,
      ALU_SUB = 3'b010,
      ALU_RSV = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SRL = 3'b101,
      ALU_OR  = 3'b110,
      ALU_AND = 3'b111
   } alu_op_e;

   // Execution FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative one-bit-per-cycle shifter for the ALU execution unit.
// A start pulse loads the operand, amount and direction; each following
// cycle shifts by one bit (zero fill) and decrements the counter. done is
// high in the cycle whose shift is the last one, and shifted carries that
// final value so the caller can capture it on the same edge.
module alu_shift_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               shift_left,
   input  logic [WIDTH-1:0]   din,
   input  logic [SHAMT_W-1:0] shamt,
   output logic [WIDTH-1:0]   shifted,
   output logic               done
);

   logic [WIDTH-1:0]   data_q;
   logic [SHAMT_W-1:0] cnt_q;
   logic               left_q;

   // Next value after one more bit of shifting
   always_comb begin
      shifted = left_q ? {data_q[WIDTH-2:0], 1'b0} : {1'b0, data_q[WIDTH-1:1]};
      done    = (cnt_q == SHAMT_W'(1));
   end

   // Load on start, then shift and count down until the counter empties
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         cnt_q  <= '0;
         left_q <= 1'b0;
      end else if (start) begin
         data_q <= din;
         cnt_q  <= shamt;
         left_q <= shift_left;
      end else if (cnt_q != '0) begin
         data_q <= shifted;
         cnt_q  <= cnt_q - SHAMT_W'(1);
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with valid/ready on both sides.
// Arithmetic/logic ops finish in one cycle; shifts iterate one bit per
// cycle through alu_shift_iter unless ALU_EXEC_BARREL_EN is defined, in
// which case a combinational barrel shifter gives every op latency 1.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       ALU_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry,
   output logic             illegal_op
);

   alu_state_e         state_q, state_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               zero_q, zero_d;
   logic               carry_q, carry_d;
   logic               ill_q, ill_d;
   logic [SHAMT_W-1:0] shamt;
   logic [WIDTH:0]     sum_add, sum_sub;

   assign shamt   = src_b[SHAMT_W-1:0];
   assign sum_add = {1'b0, src_a} + {1'b0, src_b};
   assign sum_sub = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};

`ifndef ALU_EXEC_BARREL_EN
   logic             shift_start;
   logic             shift_done;
   logic [WIDTH-1:0] shift_data;

   alu_shift_iter #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_shift (
      .clk        (clk),
      .rst        (rst),
      .start      (shift_start),
      .shift_left (ALU_control == ALU_SLL),
      .din        (src_a),
      .shamt      (shamt),
      .shifted    (shift_data),
      .done       (shift_done)
   );
`endif

   // Next-state and result/flag computation
   always_comb begin
      state_d = state_q;
      res_d   = res_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ill_d   = ill_q;
`ifndef ALU_EXEC_BARREL_EN
      shift_start = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d = ST_DONE;
               carry_d = 1'b0;
               ill_d   = 1'b0;
               case (ALU_control)
                  ALU_ADD: begin
                     res_d   = sum_add[WIDTH-1:0];
                     carry_d = sum_add[WIDTH];
                  end
                  ALU_SUB: begin
                     res_d   = sum_sub[WIDTH-1:0];
                     carry_d = sum_sub[WIDTH];
                  end
                  ALU_XOR: res_d = src_a ^ src_b;
                  ALU_OR:  res_d = src_a | src_b;
                  ALU_AND: res_d = src_a & src_b;
                  ALU_SLL, ALU_SRL: begin
`ifdef ALU_EXEC_BARREL_EN
                     res_d = (ALU_control == ALU_SLL) ? (src_a << shamt) : (src_a >> shamt);
`else
                     res_d = src_a;
                     if (shamt != '0) begin
                        state_d     = ST_SHIFT;
                        shift_start = 1'b1;
                     end
`endif
                  end
                  default: begin
                     res_d = '0;
                     ill_d = 1'b1;
                  end
               endcase
               zero_d = (res_d == '0);
            end
         end
`ifndef ALU_EXEC_BARREL_EN
         ST_SHIFT: begin
            if (shift_done) begin
               res_d   = shift_data;
               zero_d  = (shift_data == '0);
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         res_q   <= '0;
         zero_q  <= 1'b1;
         carry_q <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ill_q   <= ill_d;
      end
   end

   assign in_ready   = (state_q == ST_IDLE);
   assign out_valid  = (state_q == ST_DONE);
   assign result     = res_q;
   assign zero       = zero_q;
   assign carry      = carry_q;
   assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed test-plan cases followed
// by random ops, each compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  ALU_control;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        carry;
   logic        illegal_op;

   int vectors     = 0;
   int miscompares = 0;

   alu_exec_unit #(
      .WIDTH   (32),
      .SHAMT_W (5)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ALU_control (ALU_control),
      .src_a       (src_a),
      .src_b       (src_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .carry       (carry),
      .illegal_op  (illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model straight from the op definitions
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic c, output logic il, output int lat);
      int unsigned sh;
      longint unsigned wide;
      sh  = b % 32;
      c   = 1'b0;
      il  = 1'b0;
      lat = 1;
      case (op)
         3'b000: begin wide = longint'(a) + longint'(b); r = wide[31:0]; c = wide[32]; end
         3'b010: begin r = a - b; c = (a >= b); end
         3'b100: r = a ^ b;
         3'b110: r = a | b;
         3'b111: r = a & b;
         3'b001: begin r = a << sh; lat = 1 + sh; end
         3'b101: begin r = a >> sh; lat = 1 + sh; end
         default: begin r = '0; il = 1'b1; end
      endcase
`ifdef ALU_EXEC_BARREL_EN
      lat = 1;
`endif
   endtask

   // Issue one op, wait for its result, hold it under backpressure, retire it
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold, input bit poke);
      logic [31:0] er;
      logic ec, eil;
      int elat, lat;
      model(op, a, b, er, ec, eil, elat);
      @(negedge clk);
      check({tag, ".ready_before"}, {31'b0, in_ready}, 32'd1);
      in_valid = 1'b1; ALU_control = op; src_a = a; src_b = b;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 100) begin
         check({tag, ".busy_ready"}, {31'b0, in_ready}, 32'd0);
         @(negedge clk);
         lat++;
      end
      check({tag, ".latency"}, lat, elat);
      check({tag, ".result"}, result, er);
      check({tag, ".zero"}, {31'b0, zero}, {31'b0, er == 32'd0});
      check({tag, ".carry"}, {31'b0, carry}, {31'b0, ec});
      check({tag, ".illegal"}, {31'b0, illegal_op}, {31'b0, eil});
      for (int i = 0; i < hold; i++) begin
         if (poke) begin
            in_valid = 1'b1; ALU_control = 3'b110; src_a = $urandom; src_b = $urandom;
         end
         @(negedge clk);
         check({tag, ".hold_valid"}, {31'b0, out_valid}, 32'd1);
         check({tag, ".hold_ready"}, {31'b0, in_ready}, 32'd0);
         check({tag, ".hold_result"}, result, er);
         check({tag, ".hold_flags"}, {29'b0, zero, carry, illegal_op},
               {29'b0, er == 32'd0, ec, eil});
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".retire_valid"}, {31'b0, out_valid}, 32'd0);
      check({tag, ".retire_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   initial begin
      logic [2:0] rop;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      ALU_control = '0; src_a = '0; src_b = '0;
      repeat (2) @(negedge clk);
      check("reset.in_ready", {31'b0, in_ready}, 32'd1);
      check("reset.out_valid", {31'b0, out_valid}, 32'd0);
      check("reset.result", result, 32'd0);
      check("reset.flags", {29'b0, zero, carry, illegal_op}, 32'b100);
      rst = 1'b0;

      run_op("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
      run_op("sub_neg",  3'b010, 32'd5, 32'd7, 0, 0);
      run_op("sub_eq",   3'b010, 32'd7, 32'd7, 0, 0);
      run_op("sll_31",   3'b001, 32'h0000_0001, 32'd31, 0, 0);
      run_op("srl_0",    3'b101, 32'h8000_0000, 32'd0, 0, 0);
      run_op("xor_bp",   3'b100, 32'hF0F0_F0F0, 32'hFFFF_0000, 5, 1);
      run_op("rsv",      3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 0, 0);
      run_op("and_after_rsv", 3'b111, 32'h0000_00FF, 32'h0000_000F, 0, 0);

      // Reset in the middle of a 10-bit shift
      @(negedge clk);
      in_valid = 1'b1; ALU_control = 3'b001; src_a = 32'h0000_0003; src_b = 32'd10;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid.out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_mid.in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_mid.result", result, 32'd0);
      check("rst_mid.flags", {29'b0, zero, carry, illegal_op}, 32'b100);
      run_op("or_after_rst", 3'b110, 32'h0F00_00F0, 32'h00A0_0A00, 0, 0);

      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         run_op("rand", rop, $urandom, $urandom, int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
